traffic_light_ctrl: RTL

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_light_ctrl_if.sv | 43 ++++
 rtl/traffic_light_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic light controller and its intersection.
// The controller side uses the master modport; the intersection (sensors,
// lamp drivers) uses the slave modport.
// Optional feature macro: PED_CROSS_EN adds ped_req and walk.
interface traffic_light_ctrl_if #(
   parameter int N_DIR = 4
);
   localparam int DIR_W = ($clog2(N_DIR) > 1) ? $clog2(N_DIR) : 1;

   logic [N_DIR-1:0] req;
   logic [N_DIR-1:0] green;
   logic [N_DIR-1:0] yellow;
   logic [N_DIR-1:0] red;
   logic [DIR_W-1:0] active_dir;
`ifdef PED_CROSS_EN
   logic             ped_req;
   logic             walk;
`endif

   modport master (
      input  req,
`ifdef PED_CROSS_EN
      input  ped_req,
      output walk,
`endif
      output green,
      output yellow,
      output red,
      output active_dir
   );

   modport slave (
      output req,
`ifdef PED_CROSS_EN
      output ped_req,
      input  walk,
`endif
      input  green,
      input  yellow,
      input  red,
      input  active_dir
   );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light controller for N_DIR approaches.
// A prescaler produces a one-cycle timing tick every TICK_DIV clocks; the
// phase FSM (ALLRED -> GREEN -> YELLOW -> ALLRED ...) advances only on ticks.
// Green is extended while no other direction is requesting.
// Optional feature macro: PED_CROSS_EN adds a sticky pedestrian request and a
// WALK phase (all red, walk lamp on) served after an all-red clearance.
// All lamp outputs and active_dir are registered.
module traffic_light_ctrl #(
   parameter int N_DIR        = 4,
   parameter int TICK_DIV     = 4,
   parameter int GREEN_TICKS  = 3,
   parameter int YELLOW_TICKS = 2,
   parameter int ALLRED_TICKS = 1,
   parameter int WALK_TICKS   = 2
) (
   input logic                  clk,
   input logic                  rst,
   traffic_light_ctrl_if.master bus
);

   localparam int DIR_W = ($clog2(N_DIR) > 1) ? $clog2(N_DIR) : 1;
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // Timer only needs to hold the largest duration-1 of any phase.
   localparam int MAX_GY  = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
   localparam int MAX_GYA = (MAX_GY > ALLRED_TICKS) ? MAX_GY : ALLRED_TICKS;
   localparam int MAX_T   = (MAX_GYA > WALK_TICKS) ? MAX_GYA : WALK_TICKS;
   localparam int TMR_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
   localparam logic [DIR_W-1:0] DIR_RESET   = DIR_W'(N_DIR - 1);
   localparam logic [TMR_W-1:0] GREEN_LOAD  = TMR_W'(GREEN_TICKS - 1);
   localparam logic [TMR_W-1:0] YELLOW_LOAD = TMR_W'(YELLOW_TICKS - 1);
   localparam logic [TMR_W-1:0] ALLRED_LOAD = TMR_W'(ALLRED_TICKS - 1);
`ifdef PED_CROSS_EN
   localparam logic [TMR_W-1:0] WALK_LOAD   = TMR_W'(WALK_TICKS - 1);
`endif

   typedef enum logic [1:0] {
      ST_ALLRED = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2
`ifdef PED_CROSS_EN
      ,
      ST_WALK   = 2'd3
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [DIR_W-1:0] dir_q, dir_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [PRE_W-1:0] pre_q;
   logic             tick;
   logic             other_req;
   logic [DIR_W-1:0] rr_dir;
   logic [N_DIR-1:0] green_d, yellow_d;
`ifdef PED_CROSS_EN
   logic             ped_latch_q, ped_latch_d;
   logic             walk_d;
`endif

   assign tick = (pre_q == PRE_LAST);

   // Prescaler: free-running 0..TICK_DIV-1, restarting from 0 on reset release.
   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the values from before the clock edge, independent of block order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   // Arbitration helpers: competing demand and the round-robin winner.
   // NOTE: every variable written in an always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      other_req = 1'b0;
      rr_dir    = DIR_W'((int'(dir_q) + 1) % N_DIR);
      for (int k = 0; k < N_DIR; k++) begin
         if (bus.req[k] && (DIR_W'(k) != dir_q)) begin
            other_req = 1'b1;
         end
      end
      // Search offsets 1..N_DIR from the current owner; first hit wins.
      for (int i = N_DIR; i >= 1; i--) begin
         for (int k = 0; k < N_DIR; k++) begin
            if (bus.req[k] && (k == (int'(dir_q) + i) % N_DIR)) begin
               rr_dir = DIR_W'(k);
            end
         end
      end
   end

   // Phase FSM next-state, owner and timer; nothing moves between ticks.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      timer_d = timer_q;
`ifdef PED_CROSS_EN
      ped_latch_d = ped_latch_q;
`endif
      if (tick) begin
         case (state_q)
            ST_GREEN: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - 1'b1;
               end else if (other_req) begin
                  state_d = ST_YELLOW;
                  timer_d = YELLOW_LOAD;
               end
               // With no competing demand green is extended, timer stays 0.
            end
            ST_YELLOW: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - 1'b1;
               end else begin
                  state_d = ST_ALLRED;
                  timer_d = ALLRED_LOAD;
               end
            end
`ifdef PED_CROSS_EN
            ST_WALK: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - 1'b1;
               end else begin
                  state_d = ST_ALLRED;
                  timer_d = ALLRED_LOAD;
               end
            end
`endif
            default: begin // ST_ALLRED
               if (timer_q != '0) begin
                  timer_d = timer_q - 1'b1;
`ifdef PED_CROSS_EN
               end else if (ped_latch_q) begin
                  state_d     = ST_WALK;
                  timer_d     = WALK_LOAD;
                  ped_latch_d = 1'b0;
`endif
               end else begin
                  state_d = ST_GREEN;
                  timer_d = GREEN_LOAD;
                  dir_d   = rr_dir;
               end
            end
         endcase
      end
`ifdef PED_CROSS_EN
      // A request arriving on the WALK entry edge must not be lost.
      if (bus.ped_req) begin
         ped_latch_d = 1'b1;
      end
`endif
   end

   // Lamp decode from the next state so lamps change on the same edge as it.
   always_comb begin
      green_d  = '0;
      yellow_d = '0;
      for (int k = 0; k < N_DIR; k++) begin
         if (DIR_W'(k) == dir_d) begin
            green_d[k]  = (state_d == ST_GREEN);
            yellow_d[k] = (state_d == ST_YELLOW);
         end
      end
`ifdef PED_CROSS_EN
      walk_d = (state_d == ST_WALK);
`endif
   end

   // State, owner and timer registers; reset aborts any phase to all-red.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_ALLRED;
         dir_q   <= DIR_RESET;
         timer_q <= ALLRED_LOAD;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         timer_q <= timer_d;
      end
   end

   // Registered lamp outputs; red is always the complement of green|yellow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.green  <= '0;
         bus.yellow <= '0;
         bus.red    <= '1;
      end else begin
         bus.green  <= green_d;
         bus.yellow <= yellow_d;
         bus.red    <= ~(green_d | yellow_d);
      end
   end

   assign bus.active_dir = dir_q;

`ifdef PED_CROSS_EN
   // Sticky pedestrian request and the walk lamp.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ped_latch_q <= 1'b0;
         bus.walk    <= 1'b0;
      end else begin
         ped_latch_q <= ped_latch_d;
         bus.walk    <= walk_d;
      end
   end
`endif

endmodule
